// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the cache-to-memory path.
// Holds the arbiter state encoding, default widths and requester indices.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_DCACHE = 1'b0;
  localparam logic REQ_ICACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t busy_state(input logic idx);
    return idx ? BUSY1 : BUSY0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Block-wide memory port: read/write strobes, address, data and busywait stall.
// The cache side is the master, the memory side is the slave.
interface mem_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick: a lone request wins, a tie goes to
// the requester that was not granted last.
module rr_arbiter2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // NOTE: defaults first so every path assigns grant; otherwise a latch is inferred.
  always_comb begin
    valid = |req;
    grant = REQ_DCACHE;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = REQ_ICACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data memory between the data cache (req0) and instruction cache
// (req1): round-robin grant, command latch and busywait handshake for the winner.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  req0,
  mem_arbiter_if.slave  req1,
  mem_arbiter_if.master mem
);

  arb_state_t        state_q;
  logic              last_grant_q;
  logic              started_q;
  logic              cmd_rd_q;
  logic              cmd_wr_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;

  logic [1:0]        active;
  logic              win;
  logic              win_valid;
  logic              sel_rd;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              busy0;
  logic              busy1;
  logic              in_busy;
  logic              done;

  assign active = {req1.READ | req1.WRITE, req0.READ | req0.WRITE};

  rr_arbiter2 u_rr (
    .req        (active),
    .last_grant (last_grant_q),
    .grant      (win),
    .valid      (win_valid)
  );

  // Winner's command; a write strobe overrides a simultaneous read.
  always_comb begin
    sel_wr    = win ? req1.WRITE     : req0.WRITE;
    sel_rd    = (win ? req1.READ     : req0.READ) & ~sel_wr;
    sel_addr  = win ? req1.ADDRESS   : req0.ADDRESS;
    sel_wdata = win ? req1.WRITEDATA : req0.WRITEDATA;
  end

  assign busy0   = (state_q == BUSY0);
  assign busy1   = (state_q == BUSY1);
  assign in_busy = busy0 | busy1;
  assign done    = in_busy & started_q & ~mem.BUSYWAIT;

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_ICACHE;
      started_q    <= 1'b0;
      cmd_rd_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q     <= busy_state(win);
            started_q   <= 1'b0;
            cmd_rd_q    <= sel_rd;
            cmd_wr_q    <= sel_wr;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
          end
        end
        BUSY0, BUSY1: begin
          if (done) begin
            state_q      <= IDLE;
            last_grant_q <= busy1;
            started_q    <= 1'b0;
          end else if (mem.BUSYWAIT) begin
            started_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes drop in the completion cycle so the memory cannot start again.
  assign mem.READ      = ~RESET & in_busy & cmd_rd_q & ~done;
  assign mem.WRITE     = ~RESET & in_busy & cmd_wr_q & ~done;
  assign mem.ADDRESS   = RESET ? '0 : cmd_addr_q;
  assign mem.WRITEDATA = RESET ? '0 : cmd_wdata_q;

  assign req0.BUSYWAIT = ~RESET & active[0] & ~(busy0 & done);
  assign req1.BUSYWAIT = ~RESET & active[1] & ~(busy1 & done);
  assign req0.READDATA = (~RESET & busy0) ? mem.READDATA : '0;
  assign req1.READDATA = (~RESET & busy1) ? mem.READDATA : '0;

endmodule
